// File: rtl/vx_issue_scoreboard_pkg.sv
// vx_issue_scoreboard_pkg: shared geometry and helpers for the per-slot issue scoreboard.
package vx_issue_scoreboard_pkg;
  localparam int ISSUE_WIS   = 4;
  localparam int NUM_REGS    = 64;
  localparam int NR_BITS     = $clog2(NUM_REGS);
  localparam int ISSUE_WIS_W = ISSUE_WIS > 1 ? $clog2(ISSUE_WIS) : 1;
  function automatic int unsigned bit_idx(input int unsigned wis, input int unsigned rd, input int unsigned nregs);
    return wis * nregs + rd;
  endfunction
endpackage

// File: rtl/vx_sb_out_reg.sv
// vx_sb_out_reg: valid/ready pipe register with full throughput and async active-low reset.
module vx_sb_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_valid,
  output logic         enq_ready,
  input  logic [W-1:0] enq_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;
  always_comb begin
    enq_ready = !valid_q || out_ready;
    valid_d   = (enq_valid && enq_ready) || (valid_q && !out_ready);
    data_d    = (enq_valid && enq_ready) ? enq_data : data_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/vx_issue_scoreboard.sv
// vx_issue_scoreboard: per-issue-slot register scoreboard holding instructions until their regs are free.
module vx_issue_scoreboard
  import vx_issue_scoreboard_pkg::*;
#(
  parameter int NUM_WIS       = ISSUE_WIS,
  parameter int NUM_REGS      = vx_issue_scoreboard_pkg::NUM_REGS,
  parameter int DATAW         = 160,
  parameter int STALL_TIMEOUT = 4096,
  localparam int NRB          = $clog2(NUM_REGS),
  localparam int WIS_W        = NUM_WIS > 1 ? $clog2(NUM_WIS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIS_W-1:0] in_wis,
  input  logic             in_wb,
  input  logic [NRB-1:0]   in_rd,
  input  logic [NRB-1:0]   in_rs1,
  input  logic [NRB-1:0]   in_rs2,
  input  logic [NRB-1:0]   in_rs3,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIS_W-1:0] out_wis,
  output logic [DATAW-1:0] out_data,
  input  logic             wb_valid,
  input  logic             wb_eop,
  input  logic [WIS_W-1:0] wb_wis,
  input  logic [NRB-1:0]   wb_rd,
  output logic [31:0]      perf_stalls,
  output logic             deadlock
);
  localparam int NB   = NUM_WIS * NUM_REGS;
  localparam int SC_W = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [NB-1:0] ONE = {{(NB-1){1'b0}}, 1'b1};
  logic [NB-1:0]       inuse_d, inuse_q, inuse_eff, rel_mask, set_mask;
  logic [NUM_REGS-1:0] row;
  logic                hazard, stall, accept, enq_ready;
  logic [SC_W-1:0]     stall_cnt_d, stall_cnt_q;
  logic [31:0]         perf_d, perf_q;
  logic                deadlock_d, deadlock_q;
  // Releases in the current cycle are visible to the hazard check immediately.
  always_comb begin
    rel_mask    = (wb_valid && wb_eop) ? ONE << bit_idx(32'(wb_wis), 32'(wb_rd), NUM_REGS) : '0;
    inuse_eff   = inuse_q & ~rel_mask;
    row         = inuse_eff[in_wis*NUM_REGS +: NUM_REGS];
    hazard      = (|in_rs1 && row[in_rs1]) || (|in_rs2 && row[in_rs2]) ||
                  (|in_rs3 && row[in_rs3]) || (in_wb && |in_rd && row[in_rd]);
    in_ready    = !hazard && enq_ready;
    accept      = in_valid && in_ready;
    stall       = in_valid && hazard;
    set_mask    = (accept && in_wb && |in_rd) ? ONE << bit_idx(32'(in_wis), 32'(in_rd), NUM_REGS) : '0;
    inuse_d     = inuse_eff | set_mask;
    stall_cnt_d = (accept || !in_valid) ? '0 :
                  (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    deadlock_d  = deadlock_q || (stall && stall_cnt_q == SC_W'(STALL_TIMEOUT - 1));
    perf_d      = perf_q + 32'(stall);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inuse_q     <= '0;
      stall_cnt_q <= '0;
      perf_q      <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      inuse_q     <= inuse_d;
      stall_cnt_q <= stall_cnt_d;
      perf_q      <= perf_d;
      deadlock_q  <= deadlock_d;
    end
  end
  vx_sb_out_reg #(.W(WIS_W + DATAW)) u_out (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (in_valid && !hazard),
    .enq_ready (enq_ready),
    .enq_data  ({in_wis, in_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_wis, out_data})
  );
  assign perf_stalls = perf_q;
  assign deadlock    = deadlock_q;
endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// tb_vx_issue_scoreboard: directed table plus corner-case sequences for the issue scoreboard.
module tb_vx_issue_scoreboard;
  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 0, in_ready, in_wb = 0, out_valid, out_ready = 1;
  logic [1:0]  in_wis = 0, out_wis, wb_wis = 0;
  logic [5:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0, in_rs3 = 0, wb_rd = 0;
  logic [31:0] in_data = 0, out_data, perf_stalls;
  logic        wb_valid = 0, wb_eop = 0, deadlock;
  int n_chk = 0, n_pass = 0;
  vx_issue_scoreboard #(.NUM_WIS(4), .NUM_REGS(64), .DATAW(32), .STALL_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis),
    .in_wb(in_wb), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_wis(out_wis),
    .out_data(out_data), .wb_valid(wb_valid), .wb_eop(wb_eop), .wb_wis(wb_wis), .wb_rd(wb_rd),
    .perf_stalls(perf_stalls), .deadlock(deadlock)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic iv; logic [1:0] wis; logic wb; logic [5:0] rd, rs1, rs2, rs3;
    logic ordy, wv, we; logic [1:0] wwis; logic [5:0] wrd;
    logic x_rdy, x_ov; logic [1:0] x_wis; int x_di;
  } vec_t;
  vec_t tv[12];
  function automatic vec_t mk(input logic iv, input logic [1:0] wis, input logic wb, input logic [5:0] rd,
                              input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rs3, input logic ordy,
                              input logic wv, input logic we, input logic [1:0] wwis, input logic [5:0] wrd,
                              input logic xr, input logic xov, input logic [1:0] xwis, input int xdi);
    vec_t v;
    v.iv = iv; v.wis = wis; v.wb = wb; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
    v.ordy = ordy; v.wv = wv; v.we = we; v.wwis = wwis; v.wrd = wrd;
    v.x_rdy = xr; v.x_ov = xov; v.x_wis = xwis; v.x_di = xdi;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic drv(input logic iv, input logic [1:0] wis, input logic wb, input logic [5:0] rd,
                     input logic [5:0] rs1, input logic [31:0] data, input logic ordy);
    in_valid = iv; in_wis = wis; in_wb = wb; in_rd = rd; in_rs1 = rs1;
    in_rs2 = 0; in_rs3 = 0; in_data = data; out_ready = ordy;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tv[0]  = mk(1,0,1,5, 0,0,0, 1, 0,0,0,0, 1,1,0,0);
    tv[1]  = mk(1,0,0,0, 5,0,0, 1, 0,0,0,0, 0,0,0,0);
    tv[2]  = mk(1,0,0,0, 5,0,0, 1, 1,0,0,5, 0,0,0,0);
    tv[3]  = mk(1,0,0,0, 5,0,0, 1, 1,1,0,5, 1,1,0,3);
    tv[4]  = mk(1,1,1,7, 5,0,0, 1, 0,0,0,0, 1,1,1,4);
    tv[5]  = mk(1,0,0,0, 7,0,0, 1, 0,0,0,0, 1,1,0,5);
    tv[6]  = mk(1,1,1,7, 0,0,0, 1, 0,0,0,0, 0,0,0,5);
    tv[7]  = mk(1,0,1,0, 0,0,0, 1, 0,0,0,0, 1,1,0,7);
    tv[8]  = mk(1,0,0,0, 0,0,0, 1, 0,0,0,0, 1,1,0,8);
    tv[9]  = mk(1,1,0,0, 0,0,7, 1, 1,1,2,7, 0,0,0,8);
    tv[10] = mk(1,1,0,0, 0,7,0, 1, 1,1,1,7, 1,1,1,10);
    tv[11] = mk(0,0,0,0, 0,0,0, 0, 0,0,0,0, 0,1,1,10);
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst perf", perf_stalls, 0);
    chk("rst deadlock", deadlock, 0);
    chk("rst in_ready", in_ready, 1);
    #20 reset = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      in_valid = tv[i].iv; in_wis = tv[i].wis; in_wb = tv[i].wb; in_rd = tv[i].rd;
      in_rs1 = tv[i].rs1; in_rs2 = tv[i].rs2; in_rs3 = tv[i].rs3; in_data = 32'hD000_0000 | i;
      out_ready = tv[i].ordy; wb_valid = tv[i].wv; wb_eop = tv[i].we; wb_wis = tv[i].wwis; wb_rd = tv[i].wrd;
      #1 chk($sformatf("v%0d in_ready", i), in_ready, tv[i].x_rdy);
      tick();
      chk($sformatf("v%0d out_valid", i), out_valid, tv[i].x_ov);
      chk($sformatf("v%0d out_wis", i), out_wis, tv[i].x_wis);
      chk($sformatf("v%0d out_data", i), out_data, 32'hD000_0000 | tv[i].x_di);
    end
    wb_valid = 0; wb_eop = 0;
    chk("table perf", perf_stalls, 4);
    drv(0, 0, 0, 0, 0, 0, 1);
    tick();
    // Async reset with a busy register outstanding.
    drv(1, 2, 1, 5, 0, 32'hA1, 0);
    tick();
    chk("pre-rst out_valid", out_valid, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 0;
    #1 chk("async rst out_valid", out_valid, 0);
    chk("async rst perf", perf_stalls, 0);
    drv(1, 2, 1, 9, 0, 32'hA2, 1);
    tick();
    chk("in rst ignored", out_valid, 0);
    reset = 1;
    drv(1, 2, 0, 0, 5, 32'hA3, 1);
    #1 chk("post-rst rs1=5 ready", in_ready, 1);
    tick();
    chk("post-rst out_valid", out_valid, 1);
    chk("post-rst out_wis", out_wis, 2);
    chk("post-rst out_data", out_data, 32'hA3);
    drv(1, 2, 0, 0, 9, 32'hA4, 1);
    #1 chk("rst-time rd9 not set", in_ready, 1);
    tick();
    // Backpressure then a full-rate stream.
    drv(1, 3, 0, 0, 0, 32'hE0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d in_ready", k), in_ready, 0);
      tick();
      chk($sformatf("bp%0d out_valid", k), out_valid, 1);
      chk($sformatf("bp%0d out_data", k), out_data, 32'hA4);
    end
    for (int j = 0; j < 8; j++) begin
      drv(1, 2'(j), 1, 6'(20 + j), 0, 32'hF0 + j, 1);
      #1 chk($sformatf("st%0d in_ready", j), in_ready, 1);
      tick();
      chk($sformatf("st%0d out_valid", j), out_valid, 1);
      chk($sformatf("st%0d out_data", j), out_data, 32'hF0 + j);
    end
    // Deadlock after STALL_TIMEOUT consecutive hazard stalls.
    drv(1, 3, 1, 10, 0, 32'hB0, 1);
    tick();
    drv(1, 3, 0, 0, 10, 32'hB1, 1);
    #1 chk("dl in_ready", in_ready, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("dl at 15", deadlock, 0);
    end
    chk("dl at 16", deadlock, 1);
    chk("dl perf", perf_stalls, 16);
    wb_valid = 1; wb_eop = 1; wb_wis = 3; wb_rd = 10;
    #1 chk("dl release ready", in_ready, 1);
    tick();
    chk("dl release out", out_data, 32'hB1);
    wb_valid = 0; wb_eop = 0;
    drv(0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    chk("dl sticky", deadlock, 1);
    chk("dl perf hold", perf_stalls, 16);
    reset = 0;
    #1 chk("dl cleared by rst", deadlock, 0);
    #3 reset = 1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
